op2_fetch_sched: RTL
====================

OP2_FETCH_SCHED -- requirements
Module: op2_fetch_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning max RD cycles awaiting rdAck (used only with OP2_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports reqA / reqB  input  1  operand-2 fetch request from pipeline (A) / peripheral sequencer (B).
REQ-005 SHALL have ports srcA / srcB  input  2  operand source: 0 input image, 1 output image, 2 bit RAM, 3 byte RAM.
REQ-006 SHALL have ports addrA / addrB  input  8  resource address.
REQ-007 SHALL have ports gntA / gntB  output  1  one-cycle grant pulse.
REQ-008 SHALL have port rdReq  output  1  read strobe to the selected resource.
REQ-009 SHALL have port rdAddr  output  8  latched address of the granted request.
REQ-010 SHALL have port op2MuxSel  output  2  select to the operand-2 mux; equals latched src.
REQ-011 SHALL have port rdAck  input  1  resource data ready.
REQ-012 SHALL have port op2MuxOut  input  8  mux output data.
REQ-013 SHALL have port opData  output  8  captured operand.
REQ-014 SHALL have ports opValidA / opValidB  output  1  operand valid for owner.
REQ-015 SHALL have ports ackA / ackB  input  1  owner consumes operand.
REQ-016 SHALL have port err  output  1  timeout flag.

Function
REQ-017 SHALL implement FSM IDLE, RD, HOLD; only IDLE samples reqA/reqB.
REQ-018 IDLE with one request SHALL grant it; with both, SHALL grant the requester not served last (round-robin pointer; reset pointer favours A).
REQ-019 On grant at edge N: state RD, src/addr/owner latched, gnt pulse for owner in cycle after edge N only, rdReq=1, pointer updated.
REQ-020 RD: rdReq held 1, rdAddr/op2MuxSel held; rdAck=1 at a sampling edge SHALL capture op2MuxOut into opData, drop rdReq, enter HOLD.
REQ-021 Minimum latency: req seen in cycle 0, rdReq in cycle 1, rdAck in cycle 1 -> opValid in cycle 2.
REQ-022 HOLD: owner's opValid=1, opData stable; owner's ack SHALL return to IDLE next edge; non-owner ack ignored.
REQ-023 opValidA and opValidB SHALL never be high together; gntA and gntB SHALL never be high together.
REQ-024 rdAck outside RD SHALL be ignored.
REQ-025 Request still high after HOLD SHALL be treated as a new request in IDLE.
REQ-026 op2MuxSel, rdAddr, opData SHALL hold last values in IDLE.

Reset
REQ-027 reset=0 at an edge SHALL force IDLE, rdReq/gnt*/opValid*/err=0, op2MuxSel=0, rdAddr=0, opData=0, pointer=A, timeout counter=0, including mid-RD or mid-HOLD.

Configuration
REQ-028 Macro OP2_TIMEOUT_EN defined: counter counts RD cycles; after TIMEOUT cycles without rdAck, SHALL enter HOLD with opData=8'h00, err=1; err cleared on next grant.
REQ-029 Macro OP2_TIMEOUT_EN undefined: no counter, RD waits indefinitely, err tied 0.

Verification
REQ-030 reqA=1 srcA=3 addrA=8'h12, rdAck same cycle as rdReq, op2MuxOut=8'hA5 -> gntA pulse, rdAddr=8'h12, op2MuxSel=3, opValidA with opData=8'hA5 two cycles after req.
REQ-031 reqA and reqB held high continuously, ack immediate -> grants alternate A,B,A,B.
REQ-032 reqB srcB=2, rdAck delayed 5 cycles -> rdReq high 6 cycles, opValidB after, opData unchanged until then.
REQ-033 reset=0 during RD -> next cycle rdReq=0, state IDLE, all outputs at reset values.
REQ-034 OP2_TIMEOUT_EN, TIMEOUT=15, no rdAck -> after 15 RD cycles opValid=1, opData=8'h00, err=1; err=0 after next grant.
REQ-035 ackB asserted while A owns HOLD -> opValidA stays 1, no state change.

Source files
------------

// File: rtl/op2_fetch_sched.sv
// ============================================================================
// Module      : op2_fetch_sched
// Description : Two-requester round-robin operand-2 fetch scheduler with a
//               RD/HOLD handshake. Optional RD timeout under OP2_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module op2_fetch_sched #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reqA,
    input  logic       reqB,
    input  logic [1:0] srcA,
    input  logic [1:0] srcB,
    input  logic [7:0] addrA,
    input  logic [7:0] addrB,
    output logic       gntA,
    output logic       gntB,
    output logic       rdReq,
    output logic [7:0] rdAddr,
    output logic [1:0] op2MuxSel,
    input  logic       rdAck,
    input  logic [7:0] op2MuxOut,
    output logic [7:0] opData,
    output logic       opValidA,
    output logic       opValidB,
    input  logic       ackA,
    input  logic       ackB,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t     state_q;
    logic       owner_q;      // 0 = A, 1 = B
    logic       prio_b_q;     // 1 when B wins a tie
    logic       gntA_q, gntB_q, rdReq_q, opValidA_q, opValidB_q;
    logic [7:0] rdAddr_q, opData_q;
    logic [1:0] sel_q;
    logic       grant_b_d;
    logic       owner_ack_d;

    assign grant_b_d   = reqB & (~reqA | prio_b_q);
    assign owner_ack_d = owner_q ? ackB : ackA;

`ifdef OP2_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    assign err = err_q;
`else
    localparam int c_timeout_unused = TIMEOUT;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            prio_b_q   <= 1'b0;
            gntA_q     <= 1'b0;
            gntB_q     <= 1'b0;
            rdReq_q    <= 1'b0;
            opValidA_q <= 1'b0;
            opValidB_q <= 1'b0;
            rdAddr_q   <= 8'h00;
            opData_q   <= 8'h00;
            sel_q      <= 2'd0;
`ifdef OP2_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            gntA_q <= 1'b0;
            gntB_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (reqA || reqB) begin
                        state_q  <= S_RD;
                        owner_q  <= grant_b_d;
                        prio_b_q <= ~grant_b_d;
                        gntA_q   <= ~grant_b_d;
                        gntB_q   <= grant_b_d;
                        rdReq_q  <= 1'b1;
                        rdAddr_q <= grant_b_d ? addrB : addrA;
                        sel_q    <= grant_b_d ? srcB : srcA;
`ifdef OP2_TIMEOUT_EN
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
`endif
                    end
                end
                S_RD: begin
                    if (rdAck) begin
                        state_q    <= S_HOLD;
                        opData_q   <= op2MuxOut;
                        rdReq_q    <= 1'b0;
                        opValidA_q <= ~owner_q;
                        opValidB_q <= owner_q;
                    end
`ifdef OP2_TIMEOUT_EN
                    // Give up after TIMEOUT RD cycles and hand back a zero operand
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q    <= S_HOLD;
                        opData_q   <= 8'h00;
                        err_q      <= 1'b1;
                        rdReq_q    <= 1'b0;
                        opValidA_q <= ~owner_q;
                        opValidB_q <= owner_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                S_HOLD: begin
                    if (owner_ack_d) begin
                        state_q    <= S_IDLE;
                        opValidA_q <= 1'b0;
                        opValidB_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gntA      = gntA_q;
    assign gntB      = gntB_q;
    assign rdReq     = rdReq_q;
    assign rdAddr    = rdAddr_q;
    assign op2MuxSel = sel_q;
    assign opData    = opData_q;
    assign opValidA  = opValidA_q;
    assign opValidB  = opValidB_q;

endmodule

`default_nettype wire
